// File: rtl/chip8_audio.sv
// CHIP-8 sound output stage: plays a 128-bit pattern buffer on spkr at SAMPLE_HZ
// while the CPU requests sound, holding at least until one frame boundary.
module chip8_audio #(
  parameter int unsigned CLK_HZ    = 4857480,
  parameter int unsigned SAMPLE_HZ = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beep,
  input  logic       vsync,
  input  logic       pat_we,
  input  logic [3:0] pat_addr,
  input  logic [7:0] pat_din,
  output logic       spkr,
  output logic       playing
);

  localparam int unsigned ACC_W = $clog2(CLK_HZ + SAMPLE_HZ);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned IDX_W = 7;

  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] acc_sum;
  logic             tick_c;
  logic [7:0]       pat [16];
  logic [7:0]       pat_byte_c;
  logic             pat_bit_c;
  logic [IDX_W-1:0] idx, idx_n;
  logic             vs_q;
  logic             frame_c;
  logic             seen_frame, seen_n;
  logic             spkr_n, playing_n;

  // Fractional sample-rate accumulator; free-running, independent of the FSM.
  assign acc_sum = SUM_W'(acc) + SUM_W'(SAMPLE_HZ);
  assign tick_c  = (acc_sum >= SUM_W'(CLK_HZ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc <= '0;
    else if (tick_c) acc <= ACC_W'(acc_sum - SUM_W'(CLK_HZ));
    else acc <= ACC_W'(acc_sum);
  end

  // Pattern buffer; reset image is a 50% square of 8-sample half periods.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 16; i++) pat[i] <= i[0] ? 8'h00 : 8'hFF;
    end else if (pat_we) begin
      pat[pat_addr] <= pat_din;
    end
  end

  // MSB-first bit select; a same-edge write is seen only from the next read.
  assign pat_byte_c = pat[idx[6:3]];
  assign pat_bit_c  = pat_byte_c[~idx[2:0]];

  assign frame_c = vsync & ~vs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n   = state;
    spkr_n    = spkr;
    idx_n     = idx;
    seen_n    = seen_frame;
    case (state)
      IDLE: begin
        spkr_n = 1'b0;
        idx_n  = '0;
        if (beep) begin
          state_n = PLAY;
          seen_n  = 1'b0;
        end
      end
      PLAY, HOLD: begin
        if (tick_c) begin
          spkr_n = pat_bit_c;
          idx_n  = idx + IDX_W'(1);
        end
        if (frame_c) seen_n = 1'b1;
        if (state == PLAY) begin
          // A frame tick landing with the beep drop still counts as seen.
          if (!beep) state_n = (seen_frame || frame_c) ? IDLE : HOLD;
        end else begin
          if (beep) state_n = PLAY;
          else if (frame_c) state_n = IDLE;
        end
        if (state_n == IDLE) begin
          spkr_n = 1'b0;
          idx_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    playing_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spkr       <= 1'b0;
      playing    <= 1'b0;
      idx        <= '0;
      vs_q       <= 1'b0;
      seen_frame <= 1'b0;
    end else begin
      spkr       <= spkr_n;
      playing    <= playing_n;
      idx        <= idx_n;
      vs_q       <= vsync;
      seen_frame <= seen_n;
    end
  end

endmodule

// File: tb/tb_chip8_audio.sv
// Directed bench for chip8_audio at CLK_HZ=16, SAMPLE_HZ=4 (tick every 4th edge after reset).
module tb_chip8_audio;

  localparam int unsigned CLK_HZ    = 16;
  localparam int unsigned SAMPLE_HZ = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       beep;
  logic       vsync;
  logic       pat_we;
  logic [3:0] pat_addr;
  logic [7:0] pat_din;
  logic       spkr;
  logic       playing;

  int n_chk = 0;
  int n_fail = 0;
  int ecnt = 0;

  typedef struct {
    logic        do_wr;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] want;
  } vec_t;

  vec_t vecs [4];

  chip8_audio #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .beep     (beep),
    .vsync    (vsync),
    .pat_we   (pat_we),
    .pat_addr (pat_addr),
    .pat_din  (pat_din),
    .spkr     (spkr),
    .playing  (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (edge %0d)", name, act, want, ecnt);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  // Advance to the next sample tick edge (every 4th edge since reset release).
  task automatic to_tick();
    step();
    while (ecnt % 4 != 0) step();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    beep = 1'b0; vsync = 1'b0; pat_we = 1'b0; pat_addr = 4'd0; pat_din = 8'd0;
    reset = 1'b0;
    #3;
    check("rst_spkr", spkr, 1'b0);
    check("rst_playing", playing, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ecnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; beep = 1'b0; vsync = 1'b0; pat_we = 1'b0; pat_addr = 4'd0; pat_din = 8'd0;
    vecs[0] = '{1'b0, 8'hFF, 8'h00, 16'hFF00};
    vecs[1] = '{1'b1, 8'hA5, 8'h0F, 16'hA50F};
    vecs[2] = '{1'b1, 8'h3C, 8'h81, 16'h3C81};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 16'h00FF};
    #2;

    // Default tone with wrap past 128 samples, then reset mid-play with spkr high.
    do_reset();
    beep = 1'b1;
    step();
    check("play_entry", playing, 1'b1);
    check("pre_tick_spkr", spkr, 1'b0);
    for (int t = 0; t < 144; t++) begin
      to_tick();
      check("default_tone", spkr, ((t / 8) % 2) == 0);
    end
    to_tick();
    check("spkr_hi_before_reset", spkr, 1'b1);
    step();
    step();
    do_reset();

    // Pattern vectors: two bytes written (or defaults), 16 tick outputs compared.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      if (vecs[v].do_wr) begin
        pat_we = 1'b1; pat_addr = 4'd0; pat_din = vecs[v].b0;
        step();
        pat_addr = 4'd1; pat_din = vecs[v].b1;
        step();
        pat_we = 1'b0;
      end else begin
        step();
        step();
      end
      beep = 1'b1;
      step();
      check("vec_playing", playing, 1'b1);
      check("vec_pre_tick", spkr, 1'b0);
      for (int k = 0; k < 16; k++) begin
        to_tick();
        check("vec_bit", spkr, vecs[v].want[15-k]);
      end
      // beep drop together with a frame tick ends playback directly
      beep = 1'b0; vsync = 1'b1;
      step();
      check("vec_stop_playing", playing, 1'b0);
      check("vec_stop_spkr", spkr, 1'b0);
      vsync = 1'b0;
      step();
    end

    // Minimum duration: short beep holds until the next frame tick.
    do_reset();
    beep = 1'b1;
    step(); step(); step();
    beep = 1'b0;
    step();
    check("hold_playing", playing, 1'b1);
    check("hold_spkr", spkr, 1'b1);
    while (ecnt < 10) step();
    check("hold_still_playing", playing, 1'b1);
    vsync = 1'b1;
    step();
    check("hold_end_playing", playing, 1'b0);
    check("hold_end_spkr", spkr, 1'b0);
    vsync = 1'b0;
    step();
    check("idle_stays", playing, 1'b0);

    // A frame seen during PLAY makes a later beep drop go straight to IDLE.
    do_reset();
    beep = 1'b1;
    step();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    check("seen_playing", playing, 1'b1);
    beep = 1'b0;
    step();
    check("seen_stop_playing", playing, 1'b0);
    check("seen_stop_spkr", spkr, 1'b0);

    // Retrigger from HOLD keeps idx running.
    do_reset();
    beep = 1'b1;
    step();
    while (ecnt < 12) step();
    check("retrig_spkr_a", spkr, 1'b1);
    beep = 1'b0;
    step();
    check("retrig_hold", playing, 1'b1);
    beep = 1'b1;
    step();
    check("retrig_play", playing, 1'b1);
    while (ecnt < 32) step();
    check("retrig_bit7", spkr, 1'b1);
    to_tick();
    check("retrig_bit8", spkr, 1'b0);
    // HOLD with frame tick and beep together returns to PLAY
    beep = 1'b0;
    step();
    beep = 1'b1; vsync = 1'b1;
    step();
    check("hold_frame_beep", playing, 1'b1);
    vsync = 1'b0;
    step();
    check("hold_frame_beep_stay", playing, 1'b1);

    // Write to byte 0 on the tick that reads bit 0: old value plays.
    do_reset();
    beep = 1'b1;
    step(); step(); step();
    pat_we = 1'b1; pat_addr = 4'd0; pat_din = 8'h00;
    step();
    check("collision_old", spkr, 1'b1);
    pat_we = 1'b0;
    to_tick();
    check("collision_next", spkr, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
